// File: rtl/baseaddr_reader_pick_pkg.sv
// Shared types and helpers for the read-side frame-buffer pointer selector.
// Holds the ring size, the reader's reset pointer, the FSM state type and
// one-hot helpers that are used by the selector and its interface.
package baseaddr_reader_pick_pkg;

  localparam int unsigned NBUF = 5;

  // Disjoint from the writer's reset pointer (5'b00001).
  localparam logic [NBUF-1:0] RD_PTR_RST = 5'b00010;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StSel,
    StUpd
  } state_e;

  // True when exactly one bit is set.
  function automatic logic onehot_ok(logic [NBUF-1:0] v);
    logic [NBUF-1:0] one;
    one = {{(NBUF-1){1'b0}}, 1'b1};
    return (v != '0) && ((v & (v - one)) == '0);
  endfunction

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [2:0] onehot2idx(logic [NBUF-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = NBUF - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/baseaddr_reader_pick_if.sv
// Bus bundle between the read pointer selector, the write-side allocator,
// the read DMA master and the read timing source.
//   enable, rd_vs                       : control / async read vsync
//   wr_current_point, last_next_point   : from the write-side allocator (one-hot)
//   rd_curr_point                       : reader-owned buffer back to the allocator
//   rd_base_addr, rd_ptr_valid          : frame base address to the read DMA
//   rd_repeat, rd_frame_cnt, rd_repeat_cnt : status and statistics
// master = the selector, slave = its environment.
interface baseaddr_reader_pick_if
  import baseaddr_reader_pick_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
);
  logic              enable;
  logic              rd_vs;
  logic [NBUF-1:0]   wr_current_point;
  logic [NBUF-1:0]   last_next_point;
  logic [NBUF-1:0]   rd_curr_point;
  logic [ADDR_W-1:0] rd_base_addr;
  logic              rd_ptr_valid;
  logic              rd_repeat;
  logic [CNT_W-1:0]  rd_frame_cnt;
  logic [CNT_W-1:0]  rd_repeat_cnt;

  modport master (
    input  enable, rd_vs, wr_current_point, last_next_point,
    output rd_curr_point, rd_base_addr, rd_ptr_valid, rd_repeat,
    output rd_frame_cnt, rd_repeat_cnt
  );

  modport slave (
    output enable, rd_vs, wr_current_point, last_next_point,
    input  rd_curr_point, rd_base_addr, rd_ptr_valid, rd_repeat,
    input  rd_frame_cnt, rd_repeat_cnt
  );
endinterface

// File: rtl/baseaddr_reader_pick_vs_sync_edge.sv
// Read-vsync synchroniser and rising-edge detector.
//   wclk, wrst_n : clock, synchronous active-low reset
//   enable       : gates the rise output
//   rd_vs        : asynchronous read vsync
//   rise         : one-cycle pulse on a synchronised 0->1 of rd_vs
module baseaddr_reader_pick_vs_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic wclk,
  input  logic wrst_n,
  input  logic enable,
  input  logic rd_vs,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rd_vs};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~dly_q & enable;

endmodule

// File: rtl/baseaddr_reader_pick.sv
// Read-side frame-buffer pointer selector for the 5-buffer VDMA ring.
// On each read vsync it adopts the newest completed write buffer unless that
// buffer is invalid, being written, or already owned; otherwise the frame is
// a repeat of the current buffer. Publishes the owned buffer back to the
// allocator and its base address to the read DMA.
//   wclk, wrst_n : clock, synchronous active-low reset
//   bus          : baseaddr_reader_pick_if master (control, allocator, DMA, stats)
module baseaddr_reader_pick
  import baseaddr_reader_pick_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] FRAME_BYTES = 32'h0080_0000,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                   wclk,
  input  logic                   wrst_n,
  baseaddr_reader_pick_if.master bus
);

  localparam logic [ADDR_W-1:0] AddrRst = ADDR_W'(BASE_ADDR) + ADDR_W'(FRAME_BYTES);

  function automatic logic [ADDR_W-1:0] frame_addr(logic [2:0] idx);
    return ADDR_W'(BASE_ADDR) + ADDR_W'(idx) * ADDR_W'(FRAME_BYTES);
  endfunction

  state_e            state_q, state_d;
  logic [NBUF-1:0]   curr_q, curr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic              repeat_q, repeat_d;
  logic [CNT_W-1:0]  fcnt_q, fcnt_d;
  logic [CNT_W-1:0]  rcnt_q, rcnt_d;
  logic              rise;
  logic              cand_take;

  baseaddr_reader_pick_vs_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_vs_sync_edge (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .enable (bus.enable),
    .rd_vs  (bus.rd_vs),
    .rise   (rise)
  );

  // Candidate must be a single buffer, not the one being written, and not
  // the one already owned (which would be a repeat anyway).
  assign cand_take = onehot_ok(bus.last_next_point) &&
                     ((bus.last_next_point & bus.wr_current_point) == '0) &&
                     (bus.last_next_point != curr_q);

  always_comb begin
    state_d  = state_q;
    curr_d   = curr_q;
    addr_d   = addr_q;
    valid_d  = 1'b0;
    repeat_d = repeat_q;
    fcnt_d   = fcnt_q;
    rcnt_d   = rcnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.enable) state_d = StArm;
      end
      StArm: begin
        if (!bus.enable) state_d = StIdle;
        else if (rise)   state_d = StSel;
      end
      StSel: begin
        state_d = StUpd;
        fcnt_d  = fcnt_q + CNT_W'(1);
        if (cand_take) begin
          curr_d   = bus.last_next_point;
          repeat_d = 1'b0;
        end else begin
          repeat_d = 1'b1;
          rcnt_d   = rcnt_q + CNT_W'(1);
        end
      end
      StUpd: begin
        // A frame already in flight completes even if enable dropped.
        addr_d  = frame_addr(onehot2idx(curr_q));
        valid_d = 1'b1;
        state_d = bus.enable ? StArm : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      state_q  <= StIdle;
      curr_q   <= RD_PTR_RST;
      addr_q   <= AddrRst;
      valid_q  <= 1'b0;
      repeat_q <= 1'b0;
      fcnt_q   <= '0;
      rcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      curr_q   <= curr_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      repeat_q <= repeat_d;
      fcnt_q   <= fcnt_d;
      rcnt_q   <= rcnt_d;
    end
  end

  assign bus.rd_curr_point = curr_q;
  assign bus.rd_base_addr  = addr_q;
  assign bus.rd_ptr_valid  = valid_q;
  assign bus.rd_repeat     = repeat_q;
  assign bus.rd_frame_cnt  = fcnt_q;
  assign bus.rd_repeat_cnt = rcnt_q;

endmodule

// File: tb/tb_baseaddr_reader_pick.sv
// Self-checking bench for baseaddr_reader_pick. Counters are built 8 bits
// wide here so the wrap-around case is reachable in a short run.
module tb_baseaddr_reader_pick;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 8;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam logic [31:0] STRIDE = 32'h0080_0000;

  logic wclk = 1'b0;
  logic wrst_n;
  always #5 wclk = ~wclk;

  baseaddr_reader_pick_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  baseaddr_reader_pick #(
    .ADDR_W      (ADDR_W),
    .BASE_ADDR   (BASE),
    .FRAME_BYTES (STRIDE),
    .SYNC_STAGES (2),
    .CNT_W       (CNT_W)
  ) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: state of the reader after each completed frame.
  logic [4:0]       m_curr;
  logic [31:0]      m_addr;
  logic             m_rep;
  logic [CNT_W-1:0] m_fcnt;
  logic [CNT_W-1:0] m_rcnt;

  function automatic void model_reset();
    m_curr = 5'b00010;
    m_addr = BASE + STRIDE;
    m_rep  = 1'b0;
    m_fcnt = '0;
    m_rcnt = '0;
  endfunction

  function automatic void model_frame(logic [4:0] last, logic [4:0] wr);
    if ($countones(last) == 1 && (last & wr) == 5'b0 && last != m_curr) begin
      m_curr = last;
      m_rep  = 1'b0;
    end else begin
      m_rep  = 1'b1;
      m_rcnt = m_rcnt + CNT_W'(1);
    end
    m_fcnt = m_fcnt + CNT_W'(1);
    m_addr = BASE + STRIDE * 32'($clog2(m_curr));
  endfunction

  function automatic logic [4:0] rand_onehot();
    return 5'b00001 << $urandom_range(0, 4);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge wclk);
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, " curr"},  64'(bus.rd_curr_point), 64'(m_curr));
    check({tag, " addr"},  64'(bus.rd_base_addr),  64'(m_addr));
    check({tag, " rep"},   64'(bus.rd_repeat),     64'(m_rep));
    check({tag, " fcnt"},  64'(bus.rd_frame_cnt),  64'(m_fcnt));
    check({tag, " rcnt"},  64'(bus.rd_repeat_cnt), 64'(m_rcnt));
  endtask

  // One read frame: raise rd_vs, wait (bounded) for the pointer-valid pulse,
  // compare against the model, then drop rd_vs long enough to re-arm.
  task automatic run_frame(input logic [4:0] last, input logic [4:0] wr, input string tag);
    logic seen;
    bus.last_next_point  = last;
    bus.wr_current_point = wr;
    bus.rd_vs = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1);
      if (bus.rd_ptr_valid) seen = 1'b1;
    end
    check({tag, " valid_seen"}, 64'(seen), 64'(1));
    model_frame(last, wr);
    check_all(tag);
    bus.rd_vs = 1'b0;
    tick(1);
    check({tag, " pulse_end"}, 64'(bus.rd_ptr_valid), 64'(0));
    tick(3);
  endtask

  task automatic run_random_frame(input string tag);
    logic [4:0] last, wr;
    case ($urandom_range(0, 3))
      0:       last = 5'b0;
      1:       last = 5'($urandom_range(0, 31));
      default: last = rand_onehot();
    endcase
    // The allocator never writes into the reader's buffer.
    do wr = rand_onehot(); while (wr == m_curr);
    run_frame(last, wr, tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic       saw;
    logic [4:0] pick;

    wrst_n = 1'b0;
    bus.enable = 1'b0;
    bus.rd_vs = 1'b0;
    bus.last_next_point = 5'b0;
    bus.wr_current_point = 5'b00001;
    tick(3);
    model_reset();
    check_all("reset");
    check("reset valid", 64'(bus.rd_ptr_valid), 64'(0));
    wrst_n = 1'b1;

    // Latency of the first frame, edge by edge.
    bus.enable = 1'b1;
    tick(2);
    bus.last_next_point = 5'b00100;
    bus.wr_current_point = 5'b00001;
    bus.rd_vs = 1'b1;
    tick(3);
    check("lat e2 curr", 64'(bus.rd_curr_point), 64'(5'b00010));
    tick(1);
    check("lat e3 curr", 64'(bus.rd_curr_point), 64'(5'b00100));
    check("lat e3 valid", 64'(bus.rd_ptr_valid), 64'(0));
    tick(1);
    check("lat e4 valid", 64'(bus.rd_ptr_valid), 64'(1));
    check("lat e4 addr", 64'(bus.rd_base_addr), 64'(32'h0100_0000));
    check("lat e4 rep", 64'(bus.rd_repeat), 64'(0));
    model_frame(5'b00100, 5'b00001);
    tick(1);
    check("lat e5 valid", 64'(bus.rd_ptr_valid), 64'(0));
    check_all("first");
    bus.rd_vs = 1'b0;
    tick(4);

    // Collision with the buffer being written.
    run_frame(5'b01000, 5'b01000, "collision");
    check("collision rcnt", 64'(bus.rd_repeat_cnt), 64'(1));
    check("collision curr", 64'(bus.rd_curr_point), 64'(5'b00100));

    // Empty and multi-hot candidates.
    run_frame(5'b00000, 5'b10000, "empty");
    run_frame(5'b00011, 5'b10000, "multihot");
    check("invalid curr", 64'(bus.rd_curr_point), 64'(5'b00100));

    for (int i = 0; i < 20; i++) run_random_frame("rand");

    // Disabled: rd_vs toggles are ignored, state held.
    bus.enable = 1'b0;
    tick(2);
    saw = 1'b0;
    for (int i = 0; i < 18; i++) begin
      bus.rd_vs = (i % 6) < 3;
      tick(1);
      if (bus.rd_ptr_valid) saw = 1'b1;
    end
    bus.rd_vs = 1'b0;
    tick(4);
    check("disabled no valid", 64'(saw), 64'(0));
    check_all("disabled hold");
    bus.enable = 1'b1;
    tick(1);
    pick = (m_curr == 5'b00001) ? 5'b01000 : 5'b00001;
    run_frame(pick, 5'b10000, "reenable");
    check("reenable curr", 64'(bus.rd_curr_point), 64'(pick));

    // Enable drops while in SEL: the frame still completes, then idles.
    bus.last_next_point = 5'b10000;
    bus.wr_current_point = 5'b00100;
    bus.rd_vs = 1'b1;
    tick(3);
    bus.enable = 1'b0;
    tick(2);
    check("drop mid valid", 64'(bus.rd_ptr_valid), 64'(1));
    model_frame(5'b10000, 5'b00100);
    check_all("drop mid");
    bus.rd_vs = 1'b0;
    tick(4);
    bus.rd_vs = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (bus.rd_ptr_valid) saw = 1'b1;
    end
    check("drop mid idle", 64'(saw), 64'(0));
    bus.rd_vs = 1'b0;
    tick(4);
    bus.enable = 1'b1;
    tick(1);

    // Reset while the FSM is in UPD.
    pick = (m_curr == 5'b01000) ? 5'b00001 : 5'b01000;
    bus.last_next_point = pick;
    bus.wr_current_point = 5'b00100;
    bus.rd_vs = 1'b1;
    tick(4);
    check("pre-reset curr", 64'(bus.rd_curr_point), 64'(pick));
    wrst_n = 1'b0;
    bus.rd_vs = 1'b0;
    tick(1);
    model_reset();
    check_all("mid reset");
    check("mid reset addr", 64'(bus.rd_base_addr), 64'(32'h0080_0000));
    check("mid reset valid", 64'(bus.rd_ptr_valid), 64'(0));
    wrst_n = 1'b1;
    tick(4);

    // Frame counter wrap.
    for (int i = 0; i < (1 << CNT_W) - 1; i++) run_random_frame("wrap fill");
    check("wrap full", 64'(bus.rd_frame_cnt), 64'((1 << CNT_W) - 1));
    run_random_frame("wrap");
    check("wrap zero", 64'(bus.rd_frame_cnt), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
